// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the RV32I pipeline hazard/handshake control.
// Buffer indices follow stage order: IF/ID=0 .. MEM/WB=3.
package pipe_hazard_pkg;

  typedef enum logic {
    WAIT = 1'b0,
    DONE = 1'b1
  } mem_trk_state_t;

  localparam int BUF_IFID  = 0;
  localparam int BUF_IDEX  = 1;
  localparam int BUF_EXMEM = 2;
  localparam int BUF_MEMWB = 3;

  localparam int DEF_NUM_BUF     = 4;
  localparam int DEF_FLUSH_DEPTH = 2;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline control bundle: memory handshakes, hazard inputs, buffer/PC enables.
// master = the controller, slave = pipeline datapath and memories.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_BUF   = 4,
  parameter int REG_IDX_W = 5,
  parameter int PERF_W    = 32
);

  logic                 inst_mem_read;
  logic                 inst_mem_resp;
  logic                 data_mem_read;
  logic                 data_mem_write;
  logic                 data_mem_resp;
  logic                 mem_is_load;
  logic                 mem_is_store;
  logic                 idex_is_load;
  logic [REG_IDX_W-1:0] idex_rd;
  logic [REG_IDX_W-1:0] ifid_rs1;
  logic [REG_IDX_W-1:0] ifid_rs2;
  logic                 ifid_use_rs1;
  logic                 ifid_use_rs2;
  logic                 ex_redirect;
  logic                 advance;
  logic [NUM_BUF-1:0]   buf_load;
  logic [NUM_BUF-1:0]   buf_flush;
  logic                 pc_load;
  logic                 pc_redirect;
  logic [PERF_W-1:0]    perf_stall_cycles;
  logic [PERF_W-1:0]    perf_flushes;

  modport master (
    output inst_mem_read,
    input  inst_mem_resp,
    output data_mem_read,
    output data_mem_write,
    input  data_mem_resp,
    input  mem_is_load,
    input  mem_is_store,
    input  idex_is_load,
    input  idex_rd,
    input  ifid_rs1,
    input  ifid_rs2,
    input  ifid_use_rs1,
    input  ifid_use_rs2,
    input  ex_redirect,
    output advance,
    output buf_load,
    output buf_flush,
    output pc_load,
    output pc_redirect,
    output perf_stall_cycles,
    output perf_flushes
  );

  modport slave (
    input  inst_mem_read,
    output inst_mem_resp,
    input  data_mem_read,
    input  data_mem_write,
    output data_mem_resp,
    output mem_is_load,
    output mem_is_store,
    output idex_is_load,
    output idex_rd,
    output ifid_rs1,
    output ifid_rs2,
    output ifid_use_rs1,
    output ifid_use_rs2,
    output ex_redirect,
    input  advance,
    input  buf_load,
    input  buf_flush,
    input  pc_load,
    input  pc_redirect,
    input  perf_stall_cycles,
    input  perf_flushes
  );

endinterface

// File: rtl/mem_port_tracker.sv
// One memory port handshake tracker: latches a one-cycle response
// until the pipeline advances, so the request is not reissued.
module mem_port_tracker
  import pipe_hazard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_in,
  input  logic resp,
  input  logic advance,
  output logic mem_req,
  output logic port_done
);

  mem_trk_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT: if (req_in && resp && !advance) state_d = DONE;
      DONE: if (advance) state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT;
    else     state_q <= state_d;
  end

  assign mem_req   = req_in && (state_q == WAIT);
  assign port_done = !req_in
                  || (state_q == DONE)
                  || ((state_q == WAIT) && resp);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// In-order RV32I pipeline control: port handshakes, load-use stall, redirect.
// Optional perf counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int NUM_BUF     = DEF_NUM_BUF,
  parameter int REG_IDX_W   = 5,
  parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
  parameter int PERF_W      = 32
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.master bus
);

  localparam logic [NUM_BUF-1:0] FLUSH_MASK =
    NUM_BUF'((1 << FLUSH_DEPTH) - 1);

  logic run;
  logic inst_req, inst_done;
  logic data_req, data_done, data_op;
  logic advance;
  logic hazard;
  logic [NUM_BUF-1:0] buf_load, buf_flush;
  logic pc_load, pc_redirect;

  assign run     = !rst;
  assign data_op = bus.mem_is_load || bus.mem_is_store;

  mem_port_tracker u_inst_trk (
    .clk       (clk),
    .rst       (rst),
    .req_in    (1'b1),
    .resp      (bus.inst_mem_resp),
    .advance   (advance),
    .mem_req   (inst_req),
    .port_done (inst_done)
  );

  mem_port_tracker u_data_trk (
    .clk       (clk),
    .rst       (rst),
    .req_in    (data_op),
    .resp      (bus.data_mem_resp),
    .advance   (advance),
    .mem_req   (data_req),
    .port_done (data_done)
  );

  assign advance = run && inst_done && data_done;

  assign hazard = bus.idex_is_load
               && (bus.idex_rd != '0)
               && ((bus.ifid_use_rs1 && (bus.ifid_rs1 == bus.idex_rd))
                || (bus.ifid_use_rs2 && (bus.ifid_rs2 == bus.idex_rd)));

  // Redirect wins over a load-use stall: the stalled instruction is squashed.
  always_comb begin
    buf_load    = '0;
    buf_flush   = '0;
    pc_load     = 1'b0;
    pc_redirect = 1'b0;
    if (advance) begin
      unique case (1'b1)
        bus.ex_redirect: begin
          pc_load     = 1'b1;
          pc_redirect = 1'b1;
          buf_load    = '1;
          buf_flush   = FLUSH_MASK;
        end
        hazard && !bus.ex_redirect: begin
          buf_load                 = '1;
          buf_load[BUF_IFID]       = 1'b0;
          buf_flush[BUF_IDEX]      = 1'b1;
        end
        default: begin
          pc_load  = 1'b1;
          buf_load = '1;
        end
      endcase
    end
  end

  assign bus.inst_mem_read  = run && inst_req;
  assign bus.data_mem_read  = run && data_req && bus.mem_is_load;
  assign bus.data_mem_write = run && data_req && bus.mem_is_store
                           && !bus.mem_is_load;
  assign bus.advance        = advance;
  assign bus.buf_load       = buf_load;
  assign bus.buf_flush      = buf_flush;
  assign bus.pc_load        = pc_load;
  assign bus.pc_redirect    = pc_redirect;

`ifdef PIPE_HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_q, stall_d;
  logic [PERF_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((!advance || hazard) && (stall_q != '1))
      stall_d = stall_q + PERF_W'(1);
    if (advance && bus.ex_redirect && (flush_q != '1))
      flush_d = flush_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.perf_stall_cycles = stall_q;
  assign bus.perf_flushes      = flush_q;
`else
  assign bus.perf_stall_cycles = '0;
  assign bus.perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl against a
// transaction-level model of the pipeline control rules.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_pkg::*;

  localparam int NB = 4;
  localparam int RW = 5;
  localparam int PW = 32;
  localparam int FD = DEF_FLUSH_DEPTH;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NUM_BUF(NB), .REG_IDX_W(RW), .PERF_W(PW)) bus ();

  pipe_hazard_ctrl #(
    .NUM_BUF(NB), .REG_IDX_W(RW), .FLUSH_DEPTH(FD), .PERF_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic          imr, dmr, dmw, adv, pcl, pcr;
    logic [NB-1:0] bl, bf;
    longint        stall, fl;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model: has each port delivered its word for the instruction in flight
  bit     i_have, d_have;
  longint m_stall, m_fl;
  bit     new_op;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic pick_op();
    int k;
    k = $urandom_range(0, 9);
    bus.mem_is_load  = (k == 1 || k == 2 || k == 3 || k == 9);
    bus.mem_is_store = (k == 4 || k == 5 || k == 9);
    bus.idex_is_load = $urandom_range(0, 1);
    bus.idex_rd      = RW'($urandom_range(0, 3));
    bus.ifid_rs1     = RW'($urandom_range(0, 3));
    bus.ifid_rs2     = RW'($urandom_range(0, 3));
    bus.ifid_use_rs1 = $urandom_range(0, 1);
    bus.ifid_use_rs2 = $urandom_range(0, 1);
    bus.ex_redirect  = ($urandom_range(0, 3) == 0);
  endtask

  function automatic exp_t model_step();
    exp_t e;
    bit dop, ld, st, adv, haz, ir, dr;
    e.imr = 0; e.dmr = 0; e.dmw = 0; e.adv = 0; e.pcl = 0; e.pcr = 0;
    e.bl = '0; e.bf = '0; e.stall = 0; e.fl = 0;
    if (rst) begin
      i_have = 0; d_have = 0; m_stall = 0; m_fl = 0; new_op = 1;
      return e;
    end
    ld  = bus.mem_is_load;
    st  = bus.mem_is_store;
    ir  = bus.inst_mem_resp;
    dr  = bus.data_mem_resp;
    dop = ld || st;
    adv = (i_have || ir) && (!dop || d_have || dr);
    haz = bus.idex_is_load && (bus.idex_rd != 0)
       && ((bus.ifid_use_rs1 && bus.ifid_rs1 == bus.idex_rd)
        || (bus.ifid_use_rs2 && bus.ifid_rs2 == bus.idex_rd));
    e.imr = !i_have;
    e.dmr = dop && !d_have && ld;
    e.dmw = dop && !d_have && st && !ld;
    e.adv = adv;
    if (adv) begin
      if (bus.ex_redirect) begin
        e.pcl = 1; e.pcr = 1; e.bl = '1;
        for (int i = 0; i < FD; i++) e.bf[i] = 1'b1;
      end else if (haz) begin
        e.bl = '1; e.bl[0] = 1'b0; e.bf[1] = 1'b1;
      end else begin
        e.pcl = 1; e.bl = '1;
      end
    end
`ifdef PIPE_HAZARD_PERF_EN
    e.stall = m_stall;
    e.fl    = m_fl;
`endif
    if ((!adv || haz) && m_stall < ((64'd1 << PW) - 1)) m_stall++;
    if (adv && bus.ex_redirect && m_fl < ((64'd1 << PW) - 1)) m_fl++;
    if (adv) begin
      i_have = 0; d_have = 0;
    end else begin
      i_have = i_have || ir;
      d_have = d_have || (dop && dr);
    end
    new_op = adv;
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("inst_mem_read",  64'(bus.inst_mem_read),  64'(e.imr));
        check("data_mem_read",  64'(bus.data_mem_read),  64'(e.dmr));
        check("data_mem_write", 64'(bus.data_mem_write), 64'(e.dmw));
        check("advance",        64'(bus.advance),        64'(e.adv));
        check("buf_load",       64'(bus.buf_load),       64'(e.bl));
        check("buf_flush",      64'(bus.buf_flush),      64'(e.bf));
        check("pc_load",        64'(bus.pc_load),        64'(e.pcl));
        check("pc_redirect",    64'(bus.pc_redirect),    64'(e.pcr));
        check("perf_stall",     64'(bus.perf_stall_cycles), 64'(e.stall));
        check("perf_flushes",   64'(bus.perf_flushes),   64'(e.fl));
      end
    end
  end

  initial begin : stim
    int rst_left;
    rst = 1'b1;
    bus.inst_mem_resp = 0;
    bus.data_mem_resp = 0;
    i_have = 0; d_have = 0; m_stall = 0; m_fl = 0; new_op = 1;
    pick_op();
    rst_left = 3;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (rst_left == 0 && $urandom_range(0, 249) == 0)
        rst_left = $urandom_range(1, 3);
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      if (new_op) pick_op();
      bus.inst_mem_resp = ($urandom_range(0, 2) == 0);
      bus.data_mem_resp = ($urandom_range(0, 2) == 0);
      q.push_back(model_step());
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
